uart_rx_param: RTL and testbench

Parametrised UART receiver, the next generation of the uart_protocol RX path.
- Adds runtime parity mode (none/even/odd), 1 or 2 stop bits, start-bit glitch rejection and break detection.
- Provides a first-word-fall-through RX FIFO and an 8-bit RX status register.
- Sits between the serial pin and the bus-side register interface.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_param.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types, status bit positions and parity helper for the parametrised UART receiver.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      EVEN = 2'b01,
      ODD  = 2'b10
   } parity_mode_e;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      BREAK_WAIT = 3'd5
   } state_e;

   localparam int ST_READ_NOT_READY = 7;
   localparam int ST_OVERFLOW       = 6;
   localparam int ST_STOP_ERR       = 5;
   localparam int ST_BREAK_ERR      = 4;
   localparam int ST_PARITY_ERR     = 3;
   localparam int ST_EMPTY          = 2;
   localparam int ST_FULL           = 1;
   localparam int ST_TIMEOUT        = 0;

   // XOR reduction of up to nine data bits (unused upper bits are zero)
   function automatic logic ones_parity(input logic [8:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is valid whenever empty is low.
module uart_sync_fifo
   import uart_rx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic             push_ok,
   output logic             pop_ok
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;

   assign empty   = (count_r == {(AW + 1){1'b0}});
   assign full    = (count_r == DEPTH_C);
   assign pop_ok  = pop && !empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem_r[rd_ptr_r];

   // storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW + 1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_ok) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
            2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with runtime parity/stop config, break detection and RX FIFO.
// Optional idle-timeout status bit is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_param
   import uart_rx_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int SIZE_FIFO = 8,
   parameter int SYS_FREQ  = 100000000,
   parameter int BAUD_RATE = 9600,
   parameter int SAMPLE    = 16,
   parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_data_in,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   input  logic                 read_data,
   input  logic                 clear_status,
   output logic [DATA_SIZE-1:0] bus_data_out,
   output logic [7:0]           RX_status_register
);

   localparam int DW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
   localparam int SW = $clog2(SAMPLE);
   localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DVSR - 1);
   localparam logic [SW-1:0] S_MID    = SW'(SAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(SAMPLE - 1);
   localparam logic [SW-1:0] S_ZERO   = {SW{1'b0}};
   localparam logic [3:0]    N_LAST   = 4'(DATA_SIZE - 1);

   logic sync1_r, sync2_r, rx;
   logic [DW-1:0] div_r;
   logic tick, bit_end, par_exp;

   state_e state_r, state_n;
   logic [SW-1:0] s_cnt_r, s_cnt_n;
   logic [3:0] n_cnt_r, n_cnt_n;
   logic [DATA_SIZE-1:0] data_r, data_n;
   logic par_bit_r, par_bit_n, stop_low_r, stop_low_n, stop_idx_r, stop_idx_n;
   logic par_en_r, par_en_n, par_odd_r, par_odd_n, two_stop_r, two_stop_n;
   logic push, set_break, set_stop, set_parity;

   logic empty, full, push_ok, pop_ok, timeout;
   logic rnr_r, ovf_r, stop_err_r, brk_r, par_err_r;

   // two-flop synchronizer, idles high so reset cannot fake a start bit
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= serial_data_in;
         sync2_r <= sync1_r;
      end
   end
   assign rx = sync2_r;

   // free-running oversampling tick divider
   always_ff @(posedge clk) begin
      if (reset) begin
         div_r <= {DW{1'b0}};
      end else if (div_r == DIV_LAST) begin
         div_r <= {DW{1'b0}};
      end else begin
         div_r <= div_r + DW'(1'b1);
      end
   end
   assign tick    = (div_r == DIV_LAST);
   assign bit_end = tick && (s_cnt_r == S_LAST);
   assign par_exp = par_odd_r ? ~ones_parity(9'(data_r)) : ones_parity(9'(data_r));

   // receive FSM and datapath state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         s_cnt_r    <= S_ZERO;
         n_cnt_r    <= 4'd0;
         data_r     <= {DATA_SIZE{1'b0}};
         par_bit_r  <= 1'b0;
         stop_low_r <= 1'b0;
         stop_idx_r <= 1'b0;
         par_en_r   <= 1'b0;
         par_odd_r  <= 1'b0;
         two_stop_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         s_cnt_r    <= s_cnt_n;
         n_cnt_r    <= n_cnt_n;
         data_r     <= data_n;
         par_bit_r  <= par_bit_n;
         stop_low_r <= stop_low_n;
         stop_idx_r <= stop_idx_n;
         par_en_r   <= par_en_n;
         par_odd_r  <= par_odd_n;
         two_stop_r <= two_stop_n;
      end
   end

   // next-state and frame decode
   always_comb begin
      state_n    = state_r;
      s_cnt_n    = s_cnt_r;
      n_cnt_n    = n_cnt_r;
      data_n     = data_r;
      par_bit_n  = par_bit_r;
      stop_low_n = stop_low_r;
      stop_idx_n = stop_idx_r;
      par_en_n   = par_en_r;
      par_odd_n  = par_odd_r;
      two_stop_n = two_stop_r;
      push       = 1'b0;
      set_break  = 1'b0;
      set_stop   = 1'b0;
      set_parity = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rx) begin
               state_n    = START;
               s_cnt_n    = S_ZERO;
               par_en_n   = (parity_mode == EVEN) || (parity_mode == ODD);
               par_odd_n  = (parity_mode == ODD);
               two_stop_n = two_stop;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (tick && (s_cnt_r == S_MID)) begin
               s_cnt_n = S_ZERO;
               n_cnt_n = 4'd0;
               state_n = rx ? IDLE : DATA;
            end else if (tick) begin
               s_cnt_n = s_cnt_r + SW'(1'b1);
            end else begin
               s_cnt_n = s_cnt_r;
            end
         end
         DATA: begin
            if (bit_end) begin
               s_cnt_n = S_ZERO;
               data_n  = {rx, data_r[DATA_SIZE-1:1]};
               if (n_cnt_r == N_LAST) begin
                  state_n    = par_en_r ? PARITY : STOP;
                  stop_idx_n = 1'b0;
                  stop_low_n = 1'b0;
               end else begin
                  n_cnt_n = n_cnt_r + 4'd1;
               end
            end else if (tick) begin
               s_cnt_n = s_cnt_r + SW'(1'b1);
            end else begin
               s_cnt_n = s_cnt_r;
            end
         end
         PARITY: begin
            if (bit_end) begin
               s_cnt_n   = S_ZERO;
               par_bit_n = rx;
               state_n   = STOP;
            end else if (tick) begin
               s_cnt_n = s_cnt_r + SW'(1'b1);
            end else begin
               s_cnt_n = s_cnt_r;
            end
         end
         STOP: begin
            if (bit_end) begin
               s_cnt_n = S_ZERO;
               // an all-zero frame including the first stop bit is a line break, not a character
               if (!stop_idx_r && !rx && (data_r == {DATA_SIZE{1'b0}}) && !(par_en_r && par_bit_r)) begin
                  set_break = 1'b1;
                  state_n   = BREAK_WAIT;
               end else if (two_stop_r && !stop_idx_r) begin
                  stop_idx_n = 1'b1;
                  stop_low_n = !rx;
               end else begin
                  push       = 1'b1;
                  set_stop   = stop_low_r || !rx;
                  set_parity = par_en_r && (par_bit_r != par_exp);
                  state_n    = IDLE;
               end
            end else if (tick) begin
               s_cnt_n = s_cnt_r + SW'(1'b1);
            end else begin
               s_cnt_n = s_cnt_r;
            end
         end
         BREAK_WAIT: begin
            if (rx) begin
               state_n = IDLE;
            end else begin
               state_n = BREAK_WAIT;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   uart_sync_fifo #(
      .WIDTH (DATA_SIZE),
      .DEPTH (SIZE_FIFO)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (data_r),
      .pop       (read_data),
      .head      (bus_data_out),
      .empty     (empty),
      .full      (full),
      .push_ok   (push_ok),
      .pop_ok    (pop_ok)
   );

   // sticky error flags; a set event in the same cycle beats clear_status
   always_ff @(posedge clk) begin
      if (reset) begin
         rnr_r      <= 1'b0;
         ovf_r      <= 1'b0;
         stop_err_r <= 1'b0;
         brk_r      <= 1'b0;
         par_err_r  <= 1'b0;
      end else begin
         rnr_r      <= (read_data && empty) || (rnr_r && !clear_status);
         ovf_r      <= (push && !push_ok) || (ovf_r && !clear_status);
         stop_err_r <= set_stop || (stop_err_r && !clear_status);
         brk_r      <= set_break || (brk_r && !clear_status);
         par_err_r  <= set_parity || (par_err_r && !clear_status);
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_TICKS = 4 * (DATA_SIZE + 3) * SAMPLE;
   localparam int TW       = $clog2(TO_TICKS + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_TICKS);
   logic [TW-1:0] to_cnt_r;
   logic          timeout_r;

   // idle-with-data timer; saturates so the flag sets once per quiet period
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_r  <= {TW{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         if (push_ok || pop_ok || empty) begin
            to_cnt_r <= {TW{1'b0}};
         end else if (tick && (state_r == IDLE) && (to_cnt_r != TO_LAST)) begin
            to_cnt_r <= to_cnt_r + TW'(1'b1);
         end else begin
            to_cnt_r <= to_cnt_r;
         end
         timeout_r <= (tick && (state_r == IDLE) && !empty && !push_ok && !pop_ok
                       && (to_cnt_r == TO_LAST - TW'(1'b1)))
                      || (timeout_r && !clear_status && !pop_ok);
      end
   end
   assign timeout = timeout_r;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      RX_status_register                    = 8'h00;
      RX_status_register[ST_READ_NOT_READY] = rnr_r;
      RX_status_register[ST_OVERFLOW]       = ovf_r;
      RX_status_register[ST_STOP_ERR]       = stop_err_r;
      RX_status_register[ST_BREAK_ERR]      = brk_r;
      RX_status_register[ST_PARITY_ERR]     = par_err_r;
      RX_status_register[ST_EMPTY]          = empty;
      RX_status_register[ST_FULL]           = full;
      RX_status_register[ST_TIMEOUT]        = timeout;
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 16 clk per bit (BAUD_DVSR = 1), 8-deep FIFO.
module tb_uart_rx_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_data_in;
   logic [1:0] parity_mode;
   logic       two_stop;
   logic       read_data;
   logic       clear_status;
   logic [7:0] bus_data_out;
   logic [7:0] RX_status_register;

   int passed = 0;
   int total  = 0;

   uart_rx_param #(
      .DATA_SIZE (8),
      .SIZE_FIFO (8),
      .SYS_FREQ  (16000000),
      .BAUD_RATE (1000000),
      .SAMPLE    (16)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .serial_data_in     (serial_data_in),
      .parity_mode        (parity_mode),
      .two_stop           (two_stop),
      .read_data          (read_data),
      .clear_status       (clear_status),
      .bus_data_out       (bus_data_out),
      .RX_status_register (RX_status_register)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drives start, data, optional parity and stop bits; returns as the last stop bit begins.
   task automatic send_char(input logic [7:0] d, input logic par_en, input logic par_val,
                            input logic two, input logic stop2);
      serial_data_in = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_data_in = d[i];
         repeat (16) @(negedge clk);
      end
      if (par_en) begin
         serial_data_in = par_val;
         repeat (16) @(negedge clk);
      end
      if (two) begin
         serial_data_in = 1'b1;
         repeat (16) @(negedge clk);
         serial_data_in = stop2;
      end else begin
         serial_data_in = 1'b1;
      end
   endtask

   task automatic finish_frame();
      repeat (16) @(negedge clk);
      serial_data_in = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   task automatic pulse_read();
      read_data = 1'b1;
      @(negedge clk);
      read_data = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      serial_data_in = 1'b1;
      parity_mode    = 2'b00;
      two_stop       = 1'b0;
      read_data      = 1'b0;
      clear_status   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_status", RX_status_register, 8'h04);
      check("reset_data", bus_data_out, 8'h00);

      // 1: 8N1 0xA5, exact push latency
      send_char(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      check("t1_empty_before_push", {7'd0, RX_status_register[2]}, 8'h01);
      @(negedge clk);
      check("t1_empty_after_push", {7'd0, RX_status_register[2]}, 8'h00);
      check("t1_data", bus_data_out, 8'hA5);
      check("t1_status", RX_status_register, 8'h00);
      pulse_read();
      check("t1_status_after_read", RX_status_register, 8'h04);
      repeat (20) @(negedge clk);

      // 2: even parity, wrong parity bit on 0x07
      parity_mode = 2'b01;
      send_char(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
      finish_frame();
      check("t2_data", bus_data_out, 8'h07);
      check("t2_status", RX_status_register, 8'h08);
      pulse_clear();
      check("t2_status_cleared", RX_status_register, 8'h00);
      pulse_read();
      check("t2_status_after_read", RX_status_register, 8'h04);
      parity_mode = 2'b00;

      // 3: overflow with nine characters
      for (int c = 1; c <= 9; c++) begin
         send_char(8'(c), 1'b0, 1'b0, 1'b0, 1'b0);
         finish_frame();
         if (c == 8) check("t3_full_after_8", RX_status_register, 8'h02);
      end
      check("t3_overflow", RX_status_register, 8'h42);
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("t3_read_%0d", c), bus_data_out, 8'(c));
         pulse_read();
      end
      check("t3_drained", RX_status_register, 8'h44);
      pulse_clear();
      check("t3_cleared", RX_status_register, 8'h04);

      // 4: break, then a normal character
      serial_data_in = 1'b0;
      repeat (300) @(negedge clk);
      check("t4_break_low", RX_status_register, 8'h14);
      repeat (20) @(negedge clk);
      serial_data_in = 1'b1;
      repeat (40) @(negedge clk);
      check("t4_break_high", RX_status_register, 8'h14);
      pulse_clear();
      check("t4_cleared", RX_status_register, 8'h04);
      send_char(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_frame();
      check("t4_data", bus_data_out, 8'h3C);
      check("t4_status", RX_status_register, 8'h00);
      pulse_read();
      check("t4_empty_again", RX_status_register, 8'h04);

      // 5: start glitch, then read while empty
      serial_data_in = 1'b0;
      repeat (4) @(negedge clk);
      serial_data_in = 1'b1;
      repeat (200) @(negedge clk);
      check("t5_glitch", RX_status_register, 8'h04);
      pulse_read();
      check("t5_read_not_ready", RX_status_register, 8'h84);
      pulse_clear();
      check("t5_cleared", RX_status_register, 8'h04);

      // 6: reset mid-character, then two stop bits with the second low
      serial_data_in = 1'b0;
      repeat (16) @(negedge clk);
      serial_data_in = 1'b1;
      repeat (56) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_reset_status", RX_status_register, 8'h04);
      check("t6_reset_data", bus_data_out, 8'h00);
      repeat (200) @(negedge clk);
      check("t6_no_partial", RX_status_register, 8'h04);
      two_stop = 1'b1;
      send_char(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      finish_frame();
      check("t6_data", bus_data_out, 8'h55);
      check("t6_stop_error", RX_status_register, 8'h20);
      pulse_read();
      pulse_clear();
      check("t6_final", RX_status_register, 8'h04);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
